fp_result_byte_reader: RTL and testbench

- Read-out counterpart of the byte-wise operand loader in the float add/sub datapath.
- Accepts one 32-bit IEEE-754 result word through a valid/ready handshake.
- Presents the word one byte at a time on an 8-bit output. Each byte carries a 2-bit index using the same encoding as the loader's seldata: index k = bits [8k+7:8k].
- Bytes advance either automatically after a dwell time or manually on a button press, so a display or logic analyser can capture them.

---
 rtl/fp_result_byte_reader_if.sv | 21 ++
 rtl/fp_result_byte_reader.sv | 150 +++++++++++++++
 tb/tb_fp_result_byte_reader.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/fp_result_byte_reader_if.sv
// Result-word handshake and byte presentation bus of the float result reader.
// The master supplies result words and observes the bytes; the slave is the reader.
interface fp_result_byte_reader_if;
   logic [31:0] word_in;
   logic        word_valid;
   logic        word_ready;
   logic [7:0]  dataout;
   logic [1:0]  selout;
   logic        byte_valid;
   logic        done;

   modport master (
      output word_in, word_valid,
      input  word_ready, dataout, selout, byte_valid, done
   );

   modport slave (
      input  word_in, word_valid,
      output word_ready, dataout, selout, byte_valid, done
   );
endinterface

// File: rtl/fp_result_byte_reader.sv
// Presents one captured 32-bit float result one byte at a time, advancing
// either after a fixed dwell (auto) or on a debounced-by-edge button press
// (manual). Byte index k always refers to bits [8k+7:8k].
module fp_result_byte_reader #(
   parameter int HOLD_CYCLES = 50_000_000,
   parameter bit MSB_FIRST   = 1'b1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   mode,
   input  logic                   step,
   fp_result_byte_reader_if.slave bus,
   output logic [3:0]             leds
);

   localparam int CW = $clog2(HOLD_CYCLES);
   localparam logic [CW-1:0] DWELL_LAST = CW'(HOLD_CYCLES - 1);
   localparam logic [1:0]    IDX_FIRST  = MSB_FIRST ? 2'd3 : 2'd0;
   localparam logic [1:0]    IDX_LAST   = MSB_FIRST ? 2'd0 : 2'd3;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SHOW = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [31:0]   word_q, word_d;
   logic [1:0]    idx_q, idx_d;
   logic [CW-1:0] dwell_q, dwell_d;
   logic          mode_q;
   logic          sync1_q, sync2_q, sync3_q;
   logic          step_pulse;
   logic          advance;

   logic [7:0]    dataout_q, dataout_d;
   logic [1:0]    selout_q, selout_d;
   logic          byte_valid_q, byte_valid_d;
   logic          done_q, done_d;
   logic [3:0]    leds_q, leds_d;

   // Button synchronizer plus one extra flop for rising-edge detection
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         sync3_q <= 1'b0;
      end else begin
         sync1_q <= step;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
      end
   end

   // One pulse per press; holding the button never repeats
   assign step_pulse = sync2_q & ~sync3_q;

   // Next-state logic: capture, dwell/step advance, and the single done cycle
   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      idx_d   = idx_q;
      dwell_d = dwell_q;
      advance = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.word_valid) begin
               word_d  = bus.word_in;
               idx_d   = IDX_FIRST;
               dwell_d = '0;
               state_d = S_SHOW;
            end
         end
         S_SHOW: begin
            if (mode != mode_q) begin
               // New advance rule starts next cycle from a fresh dwell
               dwell_d = '0;
            end else begin
               if (mode) begin
                  advance = step_pulse;
                  dwell_d = '0;
               end else begin
                  advance = (dwell_q == DWELL_LAST);
                  dwell_d = dwell_q + 1'b1;
               end
               if (advance) begin
                  dwell_d = '0;
                  if (idx_q == IDX_LAST) begin
                     state_d = S_DONE;
                  end else begin
                     idx_d = MSB_FIRST ? (idx_q - 2'd1) : (idx_q + 2'd1);
                  end
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output values are derived from the next state so they register in step with it
   always_comb begin
      byte_valid_d = (state_d == S_SHOW);
      done_d       = (state_d == S_DONE);
      dataout_d    = byte_valid_d ? word_d[{idx_d, 3'b000} +: 8] : 8'h00;
      selout_d     = byte_valid_d ? idx_d : 2'd0;
      case (state_d)
         S_SHOW:  leds_d = 4'b0010;
         S_DONE:  leds_d = 4'b0100;
         default: leds_d = 4'b0001;
      endcase
   end

   // State, captured word and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         word_q       <= 32'h0;
         idx_q        <= 2'd0;
         dwell_q      <= '0;
         mode_q       <= 1'b0;
         dataout_q    <= 8'h00;
         selout_q     <= 2'd0;
         byte_valid_q <= 1'b0;
         done_q       <= 1'b0;
         leds_q       <= 4'b0001;
      end else begin
         state_q      <= state_d;
         word_q       <= word_d;
         idx_q        <= idx_d;
         dwell_q      <= dwell_d;
         mode_q       <= mode;
         dataout_q    <= dataout_d;
         selout_q     <= selout_d;
         byte_valid_q <= byte_valid_d;
         done_q       <= done_d;
         leds_q       <= leds_d;
      end
   end

   assign bus.word_ready = (state_q == S_IDLE);
   assign bus.dataout    = dataout_q;
   assign bus.selout     = selout_q;
   assign bus.byte_valid = byte_valid_q;
   assign bus.done       = done_q;
   assign leds           = leds_q;

endmodule

// File: tb/tb_fp_result_byte_reader.sv
// Directed bench: three reader instances (auto MSB-first, manual LSB-first,
// auto MSB-first with a longer dwell) sharing one clock and reset.
module tb_fp_result_byte_reader;

   logic clk;
   logic reset;
   logic a_mode, a_step, b_mode, b_step, c_mode, c_step;
   logic [3:0] a_leds, b_leds, c_leds;

   int chk_cnt;
   int pass_cnt;

   fp_result_byte_reader_if if_a ();
   fp_result_byte_reader_if if_b ();
   fp_result_byte_reader_if if_c ();

   fp_result_byte_reader #(.HOLD_CYCLES(3), .MSB_FIRST(1'b1)) dut_a (
      .clk(clk), .reset(reset), .mode(a_mode), .step(a_step), .bus(if_a.slave), .leds(a_leds));
   fp_result_byte_reader #(.HOLD_CYCLES(3), .MSB_FIRST(1'b0)) dut_b (
      .clk(clk), .reset(reset), .mode(b_mode), .step(b_step), .bus(if_b.slave), .leds(b_leds));
   fp_result_byte_reader #(.HOLD_CYCLES(5), .MSB_FIRST(1'b1)) dut_c (
      .clk(clk), .reset(reset), .mode(c_mode), .step(c_step), .bus(if_c.slave), .leds(c_leds));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic byte_a(input string tag, input logic [1:0] sel, input logic [7:0] data);
      check({tag, "_sel"}, 32'(if_a.selout), 32'(sel));
      check({tag, "_data"}, 32'(if_a.dataout), 32'(data));
      check({tag, "_bv"}, 32'(if_a.byte_valid), 32'd1);
   endtask

   task automatic byte_b(input string tag, input logic [1:0] sel, input logic [7:0] data);
      check({tag, "_sel"}, 32'(if_b.selout), 32'(sel));
      check({tag, "_data"}, 32'(if_b.dataout), 32'(data));
      check({tag, "_bv"}, 32'(if_b.byte_valid), 32'd1);
   endtask

   task automatic byte_c(input string tag, input logic [1:0] sel, input logic [7:0] data);
      check({tag, "_sel"}, 32'(if_c.selout), 32'(sel));
      check({tag, "_data"}, 32'(if_c.dataout), 32'(data));
      check({tag, "_bv"}, 32'(if_c.byte_valid), 32'd1);
   endtask

   task automatic press_b();
      b_step = 1'b1;
      repeat (10) tick();
      b_step = 1'b0;
      repeat (5) tick();
   endtask

   task automatic press_c();
      c_step = 1'b1;
      repeat (10) tick();
      c_step = 1'b0;
      repeat (5) tick();
   endtask

   initial begin
      logic [7:0] pi_bytes [4];
      logic [7:0] one_bytes [4];
      chk_cnt  = 0;
      pass_cnt = 0;
      pi_bytes  = '{8'h40, 8'h49, 8'h0F, 8'hDB};
      one_bytes = '{8'h3F, 8'h80, 8'h00, 8'h00};

      reset = 1'b0;
      a_mode = 1'b0; a_step = 1'b0;
      b_mode = 1'b1; b_step = 1'b0;
      c_mode = 1'b0; c_step = 1'b0;
      if_a.word_valid = 1'b0; if_a.word_in = 32'h0;
      if_b.word_valid = 1'b0; if_b.word_in = 32'h0;
      if_c.word_valid = 1'b0; if_c.word_in = 32'h0;

      // Reset then idle
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      check("rst_ready", 32'(if_a.word_ready), 32'd1);
      check("rst_leds", 32'(a_leds), 32'h1);
      check("rst_bv", 32'(if_a.byte_valid), 32'd0);
      check("rst_data", 32'(if_a.dataout), 32'h0);
      check("rst_done", 32'(if_a.done), 32'd0);
      tick();

      // Auto, MSB first, 3-cycle dwell
      if_a.word_in = 32'h4049_0FDB;
      if_a.word_valid = 1'b1;
      tick();
      if_a.word_valid = 1'b0;
      check("auto_ready_busy", 32'(if_a.word_ready), 32'd0);
      check("auto_leds_show", 32'(a_leds), 32'h2);
      for (int k = 0; k < 4; k++) begin
         for (int c = 0; c < 3; c++) begin
            byte_a($sformatf("auto_b%0d_c%0d", k, c), 2'(3 - k), pi_bytes[k]);
            tick();
         end
      end
      check("auto_done", 32'(if_a.done), 32'd1);
      check("auto_done_leds", 32'(a_leds), 32'h4);
      check("auto_done_bv", 32'(if_a.byte_valid), 32'd0);
      check("auto_done_ready", 32'(if_a.word_ready), 32'd0);
      tick();
      check("auto_done_once", 32'(if_a.done), 32'd0);
      check("auto_ready_after", 32'(if_a.word_ready), 32'd1);
      check("auto_leds_idle", 32'(a_leds), 32'h1);

      // Manual, LSB first
      if_b.word_in = 32'hC1A0_0000;
      if_b.word_valid = 1'b1;
      tick();
      if_b.word_valid = 1'b0;
      byte_b("man_first", 2'd0, 8'h00);
      repeat (20) tick();
      byte_b("man_hold", 2'd0, 8'h00);
      press_b();
      byte_b("man_p1", 2'd1, 8'h00);
      press_b();
      byte_b("man_p2", 2'd2, 8'hA0);
      press_b();
      byte_b("man_p3", 2'd3, 8'hC1);
      b_step = 1'b1;
      repeat (2) tick();
      check("man_p4_notyet", 32'(if_b.done), 32'd0);
      tick();
      check("man_p4_done", 32'(if_b.done), 32'd1);
      tick();
      check("man_p4_done_once", 32'(if_b.done), 32'd0);
      check("man_p4_ready", 32'(if_b.word_ready), 32'd1);
      repeat (7) tick();
      b_step = 1'b0;
      repeat (5) tick();
      press_b();
      check("man_idle_ready", 32'(if_b.word_ready), 32'd1);
      check("man_idle_bv", 32'(if_b.byte_valid), 32'd0);
      check("man_idle_leds", 32'(b_leds), 32'h1);
      check("man_idle_done", 32'(if_b.done), 32'd0);

      // Busy: second word offered throughout, taken one cycle after done
      if_a.word_in = 32'h3F80_0000;
      if_a.word_valid = 1'b1;
      tick();
      if_a.word_in = 32'h1111_1111;
      for (int k = 0; k < 4; k++) begin
         byte_a($sformatf("busy_b%0d", k), 2'(3 - k), one_bytes[k]);
         repeat (3) tick();
      end
      check("busy_done", 32'(if_a.done), 32'd1);
      tick();
      check("busy_idle_ready", 32'(if_a.word_ready), 32'd1);
      check("busy_idle_bv", 32'(if_a.byte_valid), 32'd0);
      tick();
      if_a.word_valid = 1'b0;
      byte_a("busy_second", 2'd3, 8'h11);
      repeat (12) tick();
      check("busy_second_done", 32'(if_a.done), 32'd1);
      tick();

      // Mode switch mid-word, 5-cycle dwell
      if_c.word_in = 32'h1234_5678;
      if_c.word_valid = 1'b1;
      tick();
      if_c.word_valid = 1'b0;
      byte_c("sw_b3", 2'd3, 8'h12);
      repeat (5) tick();
      byte_c("sw_b2", 2'd2, 8'h34);
      repeat (2) tick();
      c_mode = 1'b1;
      repeat (20) tick();
      byte_c("sw_manual_hold", 2'd2, 8'h34);
      press_c();
      byte_c("sw_manual_step", 2'd1, 8'h56);
      c_mode = 1'b0;
      repeat (5) tick();
      byte_c("sw_auto_before", 2'd1, 8'h56);
      tick();
      byte_c("sw_auto_after", 2'd0, 8'h78);
      repeat (5) tick();
      check("sw_done", 32'(if_c.done), 32'd1);
      tick();

      // Asynchronous reset in the middle of byte index 1
      if_a.word_in = 32'hDEAD_BEEF;
      if_a.word_valid = 1'b1;
      tick();
      if_a.word_valid = 1'b0;
      repeat (6) tick();
      byte_a("arst_pre", 2'd1, 8'hBE);
      #2 reset = 1'b0;
      #1;
      check("arst_bv", 32'(if_a.byte_valid), 32'd0);
      check("arst_data", 32'(if_a.dataout), 32'h0);
      check("arst_sel", 32'(if_a.selout), 32'd0);
      check("arst_leds", 32'(a_leds), 32'h1);
      check("arst_ready", 32'(if_a.word_ready), 32'd1);
      tick();
      check("arst_no_done", 32'(if_a.done), 32'd0);
      reset = 1'b1;
      repeat (8) tick();
      check("arst_after_ready", 32'(if_a.word_ready), 32'd1);
      check("arst_after_bv", 32'(if_a.byte_valid), 32'd0);
      check("arst_after_done", 32'(if_a.done), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
